vec_tx_4_16: RTL and testbench
==============================

# vec_tx_4_16

Vector-to-stream transmitter for the valid/ready element stream that `fc_*` layers consume. It accepts whole N-element input vectors on a wide parallel port and emits them one T-bit element per handshake, element 0 first. This is the upstream driver for a layer's `input_valid`/`input_ready`/`input_data` port. Two vector banks in ping-pong let the next vector load while the current one drains, so back-to-back vectors stream with no bubbles.

## Interface
- N, 4, elements per vector
- T, 16, element width in bits
- clk  in  1  clock; all state changes on the rising edge
- reset  in  1  asynchronous, active-low (0 = reset asserted); clears all state immediately
- vec_valid  in  1  producer presents a vector on vec_data
- vec_ready  out  1  a bank is free; a vector is accepted on a cycle with vec_valid && vec_ready
- vec_data  in  N*T  element k in bits [k*T +: T]; element 0 is sent first
- output_valid  out  1  output_data holds a valid element
- output_ready  in  1  consumer accepts; an element transfers on output_valid && output_ready
- output_data  out  T  current element (signed two's complement, passed through unchanged)

## Operation
- State:
  - bank[0..1][N][T] storage
  - full[1:0] per-bank flags
  - wr_sel: bank the next vector loads into
  - rd_sel: bank being drained
  - idx: element index, 0..N-1, width clog2(N)
- vec_ready = !full[wr_sel]. This is purely registered state, with no combinational path from any input.
- output_valid = full[rd_sel]. output_data = bank[rd_sel][idx] when output_valid is 1, else 0.
- Load (vec_valid && vec_ready):
  - bank[wr_sel] <= vec_data
  - full[wr_sel] <= 1
  - wr_sel toggles
- Drain (output_valid && output_ready):
  - If idx == N-1: idx <= 0, full[rd_sel] <= 0, rd_sel toggles.
  - Otherwise idx <= idx+1.
- Simultaneous load and drain in the same cycle are legal and independent. A load can never target the bank being drained unless that bank was already empty. If the final drain of bank X coincides with a load into bank Y, both take effect.
- vec_data is captured only on the load edge. Changes at other times have no effect.
- Stall: while output_valid && !output_ready, output_valid and output_data hold stable.
- Order is preserved: vectors leave in acceptance order and elements in index order 0..N-1.
- Reset (asynchronous, any time, including mid-vector):
  - full = 00, wr_sel = 0, rd_sel = 0, idx = 0
  - Partially sent vectors are discarded. Bank contents need not be cleared.

## Timing
- Reset values: output_valid = 0, output_data = 0, vec_ready = 1.
- Latency: a vector accepted at edge k makes element 0 valid in the cycle after edge k, i.e. 1 cycle from acceptance to output_valid.
- Throughput: with output_ready held at 1 and vectors offered continuously, output_valid stays at 1 with no gaps. One element transfers per cycle, so one vector is accepted every N cycles in steady state.
- Capacity is 2 vectors:
  - With both banks full, vec_ready = 0.
  - vec_ready returns to 1 in the cycle after the edge on which element N-1 of the draining bank transfers.
- Empty (full = 00): output_valid = 0, output_data = 0. output_ready is ignored.
- Deasserting reset takes effect at the next rising edge. No transfers occur while reset = 0.

## Test plan
- Single vector: after reset, load {0x0001, 0x0002, 0x0003, 0x0004} (element 0 = 0x0001) with output_ready = 1 → output_valid is 1 for exactly 4 cycles starting 1 cycle after load, with data 0x0001, 0x0002, 0x0003, 0x0004, then 0.
- Back-to-back: offer 3 vectors continuously with output_ready = 1 → 12 consecutive valid cycles with no bubble. vec_ready = 1 at the 1st, 2nd and 3rd load edges (2nd load into the free bank, 3rd into the bank just drained).
- Full/backpressure: output_ready = 0, offer 3 vectors → first two are accepted and vec_ready = 0 afterwards. output_valid = 1 with 0x0001 held stable. Raising output_ready drains 4 elements; vec_ready goes to 1 the cycle after the 4th transfer, and the 3rd vector loads.
- Random stalls: 1000 random vectors, vec_valid and output_ready each 50% random per cycle → output sequence equals the concatenated inputs in order. Signed values 0x8000 and 0xFFFF pass unchanged.
- Reset mid-vector: reset = 0 after 2 of 4 elements → output_valid = 0 and vec_ready = 1 immediately (asynchronously). After release, a new vector {0x00AA, 0x00BB, 0x00CC, 0x00DD} emits 0x00AA first, with no stale data.
- Simultaneous events: the final element of bank 0 transfers on the same edge bank 1 loads → no element is lost or duplicated, and bank 1's element 0 appears on the next cycle.

Source files
------------

// File: rtl/vec_tx_4_16.sv
// vec_tx_4_16: ping-pong vector-to-stream transmitter, N x T-bit elements.
// Ports: clk, reset (async low), vec_valid/vec_ready/vec_data in, output_valid/output_ready/output_data out.
module vec_tx_4_16 #(
  parameter int N = 4,
  parameter int T = 16
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           vec_valid,
  output logic           vec_ready,
  input  logic [N*T-1:0] vec_data,
  output logic           output_valid,
  input  logic           output_ready,
  output logic [T-1:0]   output_data
);

  localparam int IW = (N > 1) ? $clog2(N) : 1;
  localparam logic [IW-1:0] LAST = IW'(N - 1);

  logic [T-1:0]  bank [2][N];
  logic [1:0]    full;
  logic          wr_sel;
  logic          rd_sel;
  logic [IW-1:0] idx;

  logic load;
  logic drain;
  logic last;

  assign vec_ready    = !full[wr_sel];
  assign output_valid = full[rd_sel];
  assign output_data  = output_valid ? bank[rd_sel][idx] : '0;

  assign load  = vec_valid && vec_ready;
  assign drain = output_valid && output_ready;
  assign last  = (idx == LAST);

  // A load only ever targets an empty bank and a drain only a full one,
  // so the two updates to full[] never touch the same bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      full   <= 2'b00;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      idx    <= '0;
    end else begin
      if (load) begin
        full[wr_sel] <= 1'b1;
        wr_sel       <= ~wr_sel;
      end
      if (drain) begin
        if (last) begin
          idx          <= '0;
          full[rd_sel] <= 1'b0;
          rd_sel       <= ~rd_sel;
        end else begin
          idx <= idx + 1'b1;
        end
      end
    end
  end

  // Bank storage carries no reset; full[] alone decides what is live.
  always_ff @(posedge clk) begin
    if (load && reset) begin
      for (int k = 0; k < N; k++) begin
        bank[wr_sel][k] <= vec_data[k*T +: T];
      end
    end
  end

endmodule

// File: tb/tb_vec_tx_4_16.sv
// tb_vec_tx_4_16: scoreboard bench for vec_tx_4_16.
// Loads push element streams into a queue; a monitor pops on each transfer.
module tb_vec_tx_4_16;

  localparam int N = 4;
  localparam int T = 16;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic           vec_valid = 1'b0;
  logic           vec_ready;
  logic [N*T-1:0] vec_data = '0;
  logic           output_valid;
  logic           output_ready = 1'b0;
  logic [T-1:0]   output_data;

  vec_tx_4_16 #(.N(N), .T(T)) dut (
    .clk          (clk),
    .reset        (reset),
    .vec_valid    (vec_valid),
    .vec_ready    (vec_ready),
    .vec_data     (vec_data),
    .output_valid (output_valid),
    .output_ready (output_ready),
    .output_data  (output_data)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int n_loaded = 0;
  logic [T-1:0] exp_q [$];
  bit stall_prev = 0;
  logic [T-1:0] held = '0;

  function automatic void check(string name, logic [31:0] act,
                                logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [N*T-1:0] pack4(logic [T-1:0] a,
                                           logic [T-1:0] b,
                                           logic [T-1:0] c,
                                           logic [T-1:0] d);
    return {d, c, b, a};
  endfunction

  function automatic logic [T-1:0] rand_elem();
    int r;
    r = int'($urandom % 8);
    if (r == 0) return 16'h8000;
    if (r == 1) return 16'hFFFF;
    return T'($urandom);
  endfunction

  // Reference: an accepted vector contributes its elements 0..N-1 in order.
  always @(negedge clk) begin
    #1;
    if (reset && vec_valid && vec_ready) begin
      for (int k = 0; k < N; k++) exp_q.push_back(vec_data[k*T +: T]);
      n_loaded++;
    end
  end

  // Monitor: compare every transfer and stall behaviour.
  always @(negedge clk) begin
    if (!reset) begin
      stall_prev = 0;
    end else begin
      if (stall_prev) begin
        check("stall_valid", 32'(output_valid), 32'd1);
        check("stall_data", 32'(output_data), 32'(held));
      end
      if (output_valid) begin
        if (output_ready) begin
          if (exp_q.size() == 0)
            check("extra_elem", 32'(output_valid), 32'd0);
          else
            check("elem", 32'(output_data), 32'(exp_q.pop_front()));
        end
      end else begin
        check("idle_data", 32'(output_data), 32'd0);
      end
      stall_prev = output_valid && !output_ready;
      held = output_data;
    end
  end

  task automatic send_vec(input logic [N*T-1:0] v);
    int b;
    b = 0;
    vec_data = v;
    vec_valid = 1'b1;
    @(negedge clk);
    while (!vec_ready && b < 200) begin
      @(negedge clk);
      b++;
    end
    if (!vec_ready) check("load_timeout", 32'(vec_ready), 32'd1);
    @(posedge clk);
    #1;
    vec_valid = 1'b0;
  endtask

  task automatic wait_empty();
    int b;
    b = 0;
    while ((exp_q.size() != 0 || output_valid) && b < 5000) begin
      @(negedge clk);
      b++;
    end
    check("drain_done", 32'(exp_q.size()), 32'd0);
    @(posedge clk);
    #1;
  endtask

  logic [N*T-1:0] v0;
  logic [N*T-1:0] v1;
  logic [T-1:0] e6;
  int base;
  int cyc;
  int cnt;

  initial begin
    #2;
    check("reset_valid", 32'(output_valid), 32'd0);
    check("reset_data", 32'(output_data), 32'd0);
    check("reset_ready", 32'(vec_ready), 32'd1);
    @(posedge clk);
    #1;
    reset = 1'b1;

    // Single vector: latency 1, four valid cycles, then idle.
    output_ready = 1'b1;
    send_vec(pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t1_valid", 32'(output_valid), (i < 4) ? 32'd1 : 32'd0);
      check("t1_data", 32'(output_data), (i < 4) ? 32'(i + 1) : 32'd0);
    end
    @(posedge clk);
    #1;

    // Back-to-back: three vectors held on offer, 12 gapless valid cycles.
    fork
      begin
        for (int v = 0; v < 3; v++) begin
          int b;
          b = 0;
          for (int k = 0; k < N; k++)
            vec_data[k*T +: T] = T'(256 * (v + 1) + k);
          vec_valid = 1'b1;
          @(negedge clk);
          while (!vec_ready && b < 50) begin
            @(negedge clk);
            b++;
          end
          check("t2_ready", 32'(vec_ready), 32'd1);
          @(posedge clk);
          #1;
        end
        vec_valid = 1'b0;
      end
      begin
        int run;
        int b;
        run = 0;
        b = 0;
        @(negedge clk);
        while (!output_valid && b < 50) begin
          @(negedge clk);
          b++;
        end
        while (output_valid && run < 40) begin
          run++;
          @(negedge clk);
        end
        check("t2_run", 32'(run), 32'd12);
      end
    join
    wait_empty();

    // Backpressure: two vectors fill both banks, third waits.
    output_ready = 1'b0;
    send_vec(pack4(16'h0001, 16'h0002, 16'h0003, 16'h0004));
    send_vec(pack4(16'h0011, 16'h0012, 16'h0013, 16'h0014));
    vec_data = pack4(16'h0021, 16'h0022, 16'h0023, 16'h0024);
    vec_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t3_full_ready", 32'(vec_ready), 32'd0);
      check("t3_hold_valid", 32'(output_valid), 32'd1);
      check("t3_hold_data", 32'(output_data), 32'h0001);
    end
    @(posedge clk);
    #1;
    output_ready = 1'b1;
    cnt = 0;
    @(negedge clk);
    while (!vec_ready && cnt < 20) begin
      cnt++;
      @(negedge clk);
    end
    check("t3_ready_delay", 32'(cnt), 32'd4);
    @(posedge clk);
    #1;
    vec_valid = 1'b0;
    wait_empty();

    // Random traffic with random stalls on both sides.
    base = n_loaded;
    cyc = 0;
    while (n_loaded < base + 1000 && cyc < 60000) begin
      vec_valid = 1'($urandom % 2);
      for (int k = 0; k < N; k++) vec_data[k*T +: T] = rand_elem();
      output_ready = 1'($urandom % 2);
      @(posedge clk);
      #1;
      cyc++;
    end
    vec_valid = 1'b0;
    output_ready = 1'b1;
    check("t4_count", 32'(n_loaded - base >= 1000), 32'd1);
    wait_empty();

    // Reset in the middle of a vector.
    send_vec(pack4(16'h0011, 16'h0022, 16'h0033, 16'h0044));
    @(posedge clk);
    @(posedge clk);
    #3;
    reset = 1'b0;
    exp_q.delete();
    #1;
    check("t5_rst_valid", 32'(output_valid), 32'd0);
    check("t5_rst_ready", 32'(vec_ready), 32'd1);
    check("t5_rst_data", 32'(output_data), 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    send_vec(pack4(16'h00AA, 16'h00BB, 16'h00CC, 16'h00DD));
    @(negedge clk);
    check("t5_first_valid", 32'(output_valid), 32'd1);
    check("t5_first_data", 32'(output_data), 32'h00AA);
    wait_empty();

    // Final element of bank 0 leaves on the edge bank 1 loads.
    reset = 1'b0;
    exp_q.delete();
    @(posedge clk);
    #1;
    reset = 1'b1;
    v0 = pack4(16'h0101, 16'h0102, 16'h0103, 16'h0104);
    v1 = pack4(16'h0201, 16'h0202, 16'h0203, 16'h0204);
    send_vec(v0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      e6 = (i < 4) ? v0[i*T +: T] : v1[(i-4)*T +: T];
      check("t6_valid", 32'(output_valid), 32'd1);
      check("t6_data", 32'(output_data), 32'(e6));
      if (i == 3) begin
        check("t6_ready", 32'(vec_ready), 32'd1);
        vec_data = v1;
        vec_valid = 1'b1;
      end
      if (i == 4) vec_valid = 1'b0;
    end
    wait_empty();

    check("final_queue", 32'(exp_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
